// File: rtl/nco_sincos.sv
// nco_sincos: phase accumulator plus quarter-wave sine LUT that turns a
// phase (radians x 512, range [-PI, PI)) into an AMP-scaled cos/sin pair.
// Four registered stages: accumulate, quadrant fold, ROM read, sign apply.
//
// Strobe semantics: input_strobe is a request that is taken on any rising
// edge where enable=1; there is no back-pressure. Each taken request yields
// exactly one output_strobe cycle, in order. When enable=0 every register
// holds and output_strobe is held low.
module nco_sincos #(
    parameter int PHASE_WIDTH = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int PI          = 1608,
    parameter int PI_2        = 804,
    parameter int AMP         = 16384
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   phase_load,
    input  logic [PHASE_WIDTH-1:0] phase_init,
    input  logic [PHASE_WIDTH-1:0] freq_step,
    input  logic                   input_strobe,
    output logic [OUT_WIDTH-1:0]   out_cos,
    output logic [OUT_WIDTH-1:0]   out_sin,
    output logic                   output_strobe
);

    localparam int ADDR_W = $clog2(PI_2 + 1);
    localparam logic signed [PHASE_WIDTH-1:0] PI_S     = PHASE_WIDTH'(PI);
    localparam logic signed [PHASE_WIDTH-1:0] PI_2_S   = PHASE_WIDTH'(PI_2);
    localparam logic signed [PHASE_WIDTH-1:0] TWO_PI_S = PHASE_WIDTH'(2 * PI);

    // Single correction into [-PI, PI); input ranges make one step enough.
    function automatic logic signed [PHASE_WIDTH-1:0] wrap(
        input logic signed [PHASE_WIDTH-1:0] x
    );
        if (x >= PI_S) return x - TWO_PI_S;
        if (x < -PI_S) return x + TWO_PI_S;
        return x;
    endfunction

    // Elaboration-time round(AMP*sin(k/512)) via a fixed-point Taylor series
    // (2^40 scale), so the table needs no real arithmetic or external file.
    function automatic logic [OUT_WIDTH-1:0] lut_value(input int k);
        longint t;
        longint sum;
        longint kk;
        kk  = longint'(k) * longint'(k);
        t   = longint'(k) <<< 31;
        sum = 0;
        for (int n = 1; n < 30; n += 2) begin
            sum = sum + t;
            t   = -(t * kk) / (longint'(262144) * longint'((n + 1) * (n + 2)));
        end
        return OUT_WIDTH'((sum * longint'(AMP) + (longint'(1) <<< 39)) >>> 40);
    endfunction

    logic [OUT_WIDTH-1:0] lut [0:PI_2];

    for (genvar k = 0; k <= PI_2; k++) begin : g_lut
        localparam logic [OUT_WIDTH-1:0] LV = lut_value(k);
        assign lut[k] = LV;
    end

    // Stage 0 state
    logic signed [PHASE_WIDTH-1:0] acc;
    logic signed [PHASE_WIDTH-1:0] p_q;
    logic                          v0;
    // Stage 1 state
    logic [ADDR_W-1:0]             sin_addr_q, cos_addr_q;
    logic                          sin_neg1, cos_neg1, v1;
    // Stage 2 state
    logic [OUT_WIDTH-1:0]          sin_rom_q, cos_rom_q;
    logic                          sin_neg2, cos_neg2, v2;
    // Stage 3 state
    logic                          v3;

    logic signed [PHASE_WIDTH-1:0] init_w, p_next, acc_step;
    logic [ADDR_W-1:0]             sin_addr_d, cos_addr_d;
    logic                          sin_neg_d, cos_neg_d;

    // Sample phase selection and next accumulator value.
    always_comb begin
        init_w   = wrap($signed(phase_init));
        p_next   = phase_load ? init_w : acc;
        acc_step = wrap(p_next + $signed(freq_step));
    end

    // Quadrant fold of the registered sample phase into two LUT addresses.
    always_comb begin
        sin_addr_d = '0;
        cos_addr_d = '0;
        sin_neg_d  = 1'b0;
        cos_neg_d  = 1'b0;
        if (!p_q[PHASE_WIDTH-1] && p_q <= PI_2_S) begin
            sin_addr_d = ADDR_W'(p_q);
            cos_addr_d = ADDR_W'(PI_2_S - p_q);
        end else if (!p_q[PHASE_WIDTH-1]) begin
            sin_addr_d = ADDR_W'(PI_S - p_q);
            cos_addr_d = ADDR_W'(p_q - PI_2_S);
            cos_neg_d  = 1'b1;
        end else if (p_q >= -PI_2_S) begin
            sin_addr_d = ADDR_W'(-p_q);
            cos_addr_d = ADDR_W'(PI_2_S + p_q);
            sin_neg_d  = 1'b1;
        end else begin
            sin_addr_d = ADDR_W'(PI_S + p_q);
            cos_addr_d = ADDR_W'(-p_q - PI_2_S);
            sin_neg_d  = 1'b1;
            cos_neg_d  = 1'b1;
        end
    end

    // Stage 0: latch the sample phase and advance (or load) the accumulator.
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc <= '0;
            p_q <= '0;
            v0  <= 1'b0;
        end else if (enable) begin
            v0 <= input_strobe;
            if (input_strobe) begin
                p_q <= p_next;
                acc <= acc_step;
            end else if (phase_load) begin
                acc <= init_w;
            end
        end
    end

    // Stage 1: register LUT addresses and result signs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sin_addr_q <= '0;
            cos_addr_q <= '0;
            sin_neg1   <= 1'b0;
            cos_neg1   <= 1'b0;
            v1         <= 1'b0;
        end else if (enable) begin
            sin_addr_q <= sin_addr_d;
            cos_addr_q <= cos_addr_d;
            sin_neg1   <= sin_neg_d;
            cos_neg1   <= cos_neg_d;
            v1         <= v0;
        end
    end

    // Stage 2: dual-read quarter-wave ROM with registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sin_rom_q <= '0;
            cos_rom_q <= '0;
            sin_neg2  <= 1'b0;
            cos_neg2  <= 1'b0;
            v2        <= 1'b0;
        end else if (enable) begin
            sin_rom_q <= lut[sin_addr_q];
            cos_rom_q <= lut[cos_addr_q];
            sin_neg2  <= sin_neg1;
            cos_neg2  <= cos_neg1;
            v2        <= v1;
        end
    end

    // Stage 3: apply signs; outputs only move when a valid sample arrives.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_cos <= '0;
            out_sin <= '0;
            v3      <= 1'b0;
        end else if (enable) begin
            v3 <= v2;
            if (v2) begin
                out_cos <= cos_neg2 ? -cos_rom_q : cos_rom_q;
                out_sin <= sin_neg2 ? -sin_rom_q : sin_rom_q;
            end
        end
    end

    assign output_strobe = v3 & enable;

endmodule

// File: tb/tb_nco_sincos.sv
// Testbench for nco_sincos: directed test-plan steps followed by random
// traffic, all compared against a phase-level reference model.
module tb_nco_sincos;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        phase_load;
  logic [31:0] phase_init;
  logic [31:0] freq_step;
  logic        input_strobe;
  logic [15:0] out_cos;
  logic [15:0] out_sin;
  logic        output_strobe;

  nco_sincos dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .phase_load   (phase_load),
    .phase_init   (phase_init),
    .freq_step    (freq_step),
    .input_strobe (input_strobe),
    .out_cos      (out_cos),
    .out_sin      (out_sin),
    .output_strobe(output_strobe)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int n_asserts = 0;
  int n_fail    = 0;
  int cycle_no  = 0;
  bit do_check  = 0;

  int acc_m     = 0;
  int pend_cnt[$];
  int pend_cos[$];
  int pend_sin[$];
  bit strobe_m  = 0;
  int cos_m     = 0;
  int sin_m     = 0;

  int dir_cos[$];
  int dir_sin[$];
  bit dir_valid = 0;
  int dir_c     = 0;
  int dir_s     = 0;

  function automatic int wrapm(int x);
    if (x >= 1608) return x - 3216;
    if (x < -1608) return x + 3216;
    return x;
  endfunction

  function automatic int lval(int k);
    return int'(16384.0 * $sin(real'(k) / 512.0));
  endfunction

  function automatic void fold(input int p, output int c, output int s);
    if (p >= 0 && p <= 804) begin
      s = lval(p);          c = lval(804 - p);
    end else if (p > 804) begin
      s = lval(1608 - p);   c = -lval(p - 804);
    end else if (p >= -804) begin
      s = -lval(-p);        c = lval(804 + p);
    end else begin
      s = -lval(1608 + p);  c = -lval(-p - 804);
    end
  endfunction

  task automatic model_edge();
    int p, c, s;
    if (!reset) begin
      acc_m = 0;
      pend_cnt.delete(); pend_cos.delete(); pend_sin.delete();
      strobe_m = 0; cos_m = 0; sin_m = 0;
    end else if (enable) begin
      foreach (pend_cnt[i]) pend_cnt[i] = pend_cnt[i] - 1;
      strobe_m = 0;
      if (pend_cnt.size() > 0 && pend_cnt[0] == 0) begin
        void'(pend_cnt.pop_front());
        cos_m = pend_cos.pop_front();
        sin_m = pend_sin.pop_front();
        strobe_m = 1;
        if (dir_cos.size() > 0) begin
          dir_c = dir_cos.pop_front();
          dir_s = dir_sin.pop_front();
          dir_valid = 1;
        end
      end
      if (input_strobe) begin
        p = phase_load ? wrapm($signed(phase_init)) : acc_m;
        fold(p, c, s);
        pend_cnt.push_back(3);
        pend_cos.push_back(c);
        pend_sin.push_back(s);
        acc_m = wrapm(p + $signed(freq_step));
      end else if (phase_load) begin
        acc_m = wrapm($signed(phase_init));
      end
    end
  endtask

  // ---------------- checks ----------------
  task automatic check();
    logic        es;
    logic [15:0] ec, esn;
    es  = strobe_m & enable;
    ec  = 16'(cos_m);
    esn = 16'(sin_m);
    n_asserts++;
    assert (output_strobe === es) else begin
      n_fail++;
      $error("FAIL strobe cyc=%0d got=%b exp=%b", cycle_no, output_strobe, es);
    end
    n_asserts++;
    assert (out_cos === ec) else begin
      n_fail++;
      $error("FAIL cos cyc=%0d got=%0d exp=%0d", cycle_no, $signed(out_cos), $signed(ec));
    end
    n_asserts++;
    assert (out_sin === esn) else begin
      n_fail++;
      $error("FAIL sin cyc=%0d got=%0d exp=%0d", cycle_no, $signed(out_sin), $signed(esn));
    end
    if (dir_valid && es) begin
      dir_valid = 0;
      n_asserts++;
      assert (out_cos === 16'(dir_c)) else begin
        n_fail++;
        $error("FAIL plan_cos cyc=%0d got=%0d exp=%0d", cycle_no, $signed(out_cos), dir_c);
      end
      n_asserts++;
      assert (out_sin === 16'(dir_s)) else begin
        n_fail++;
        $error("FAIL plan_sin cyc=%0d got=%0d exp=%0d", cycle_no, $signed(out_sin), dir_s);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit en, input bit rst_n, input bit ld,
                     input int init, input int stp, input bit stb);
    @(negedge clock);
    enable       = en;
    reset        = rst_n;
    phase_load   = ld;
    phase_init   = 32'(init);
    freq_step    = 32'(stp);
    input_strobe = stb;
    #1;
    if (do_check) check();
    @(posedge clock);
    model_edge();
    cycle_no++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 0);
  endtask

  task automatic plan(input int c, input int s);
    dir_cos.push_back(c);
    dir_sin.push_back(s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 0; enable = 1; phase_load = 0;
    phase_init = '0; freq_step = '0; input_strobe = 0;

    // reset, then check the cleared state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    do_check = 1;
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);

    // constant phase 0 from reset
    for (int i = 0; i < 8; i++) plan(16384, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 1);
    idle(6);

    // quarter-turn steps including the +PI -> -PI wrap
    plan(0, 16384); plan(-16384, 0); plan(0, -16384); plan(16384, 0); plan(0, 16384);
    cyc(1, 1, 1, 804, 804, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 804, 1);
    idle(6);

    // 3/8 turn and the -PI boundary
    plan(-11582, 11582);
    cyc(1, 1, 1, 1206, 0, 1);
    idle(5);
    plan(-16384, 0);
    cyc(1, 1, 1, -1608, 0, 1);
    idle(6);

    // load without a strobe, then stalls inside the pipeline window
    cyc(1, 1, 1, 402, 100, 0);
    cyc(1, 1, 0, 0, 100, 1);
    cyc(1, 1, 0, 0, 100, 1);
    cyc(0, 1, 0, 0, 100, 1);
    cyc(0, 1, 0, 0, 100, 1);
    cyc(1, 1, 0, 0, 100, 1);
    cyc(1, 1, 0, 0, 100, 1);
    cyc(1, 1, 0, 0, 100, 0);
    cyc(0, 1, 0, 0, 100, 0);
    idle(8);

    // reset while samples are in flight
    cyc(1, 1, 1, 500, 300, 1);
    cyc(1, 1, 0, 0, 300, 1);
    cyc(1, 0, 0, 0, 300, 0);
    idle(6);
    plan(16384, 0);
    cyc(1, 1, 0, 0, 0, 1);
    idle(6);

    // load and strobe together
    plan(0, -16384);
    cyc(1, 1, 1, -804, 100, 1);
    cyc(1, 1, 0, 0, 100, 1);
    idle(6);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) != 0),
          ($urandom_range(0, 99) != 0),
          ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, 3215)) - 1608,
          int'($urandom_range(0, 3214)) - 1607,
          ($urandom_range(0, 9) < 6));
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
